// File: rtl/bec_affine_div.sv
// Affine conversion w = in_w / in_z over GF(2^M) by binary-Euclid division.
// One reduction step per clock; the result is held in DONE until consumed.
module bec_affine_div #(
  parameter int          M    = 163,
  parameter logic [M-1:0] POLY = 163'hC9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_w,
  input  logic [M-1:0] in_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_w,
  output logic         out_err,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [M:0] F   = {1'b1, POLY};
  localparam logic [M:0] ONE = (M+1)'(1);

  // Index of the highest set bit; 0 for an all-zero word.
  function automatic int deg(input logic [M:0] x);
    int d;
    d = 0;
    for (int i = 0; i <= M; i++)
      if (x[i]) d = i;
    return d;
  endfunction

  state_t       state, nxt;
  logic [M:0]   a, b;
  logic [M-1:0] u, v;
  logic [M-1:0] ux, u_div_x;
  logic         a_one, deg_lt;

  always_comb begin
    ux      = u ^ POLY;
    // u/x mod f: when u is odd, add f first so the shift is exact
    u_div_x = u[0] ? {1'b1, ux[M-1:1]} : {1'b0, u[M-1:1]};
    a_one   = (a == ONE);
    deg_lt  = deg(a) < deg(b);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (in_valid) nxt = (in_z == '0) ? DONE : CALC;
      CALC: if (a_one) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == CALC);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      u       <= '0;
      v       <= '0;
      out_w   <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (in_z == '0) begin
            out_w   <= '0;
            out_err <= 1'b1;
          end else begin
            a       <= {1'b0, in_z};
            b       <= F;
            u       <= in_w;
            v       <= '0;
            out_err <= 1'b0;
          end
        end
        CALC: begin
          if (a_one) begin
            out_w <= u;
          end else if (!a[0]) begin
            a <= a >> 1;
            u <= u_div_x;
          end else if (deg_lt) begin
            a <= a ^ b;
            b <= a;
            u <= u ^ v;
            v <= u;
          end else begin
            a <= a ^ b;
            u <= u ^ v;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bec_affine_div.sv
// Directed checks of bec_affine_div plus a few random pairs verified by multiplying back.
module tb_bec_affine_div;
  localparam int          M    = 163;
  localparam logic [M-1:0] POLY = 163'hC9;
  localparam logic [M-1:0] XINV = (M'(1) << 162) | M'(163'h64);

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err, busy;
  logic [M-1:0] in_w = '0, in_z = '0, out_w;

  int checks = 0, errors = 0;

  bec_affine_div #(.M(M), .POLY(POLY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_z(in_z), .out_valid(out_valid), .out_ready(out_ready),
    .out_w(out_w), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] p, s;
    logic         c;
    p = '0;
    s = x;
    for (int i = 0; i < M; i++) begin
      if (y[i]) p ^= s;
      c = s[M-1];
      s = s << 1;
      if (c) s ^= POLY;
    end
    return p;
  endfunction

  // Present a pair, wait for out_valid; lat counts edges from accept edge (inclusive).
  task automatic send(input logic [M-1:0] w, input logic [M-1:0] z, output int lat);
    @(negedge clk);
    in_w = w; in_z = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4*M + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("timeout", M'(0), M'(1));
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [M-1:0] dw [8] = '{M'(1), M'(1), M'(0), M'(4), M'(3), M'(3), M'(1), M'(1) << 162};
  logic [M-1:0] dz [8] = '{M'(1), M'(2), M'(5), M'(2), M'(1), M'(3), XINV,  M'(1) << 162};
  logic [M-1:0] dq [8] = '{M'(1), XINV,  M'(0), M'(2), M'(3), M'(1), M'(2), M'(1)};

  initial begin
    int lat, changes;
    logic [M-1:0] hw, rw, rz;
    logic         he;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", M'(in_ready), M'(1));
    chk("rst_out_valid", M'(out_valid), M'(0));
    chk("rst_busy", M'(busy), M'(0));
    chk("rst_out_w", out_w, M'(0));
    chk("rst_out_err", M'(out_err), M'(0));
    @(negedge clk) rst = 1'b0;

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      send(dw[i], dz[i], lat);
      chk($sformatf("dir%0d_w", i), out_w, dq[i]);
      chk($sformatf("dir%0d_err", i), M'(out_err), M'(0));
      if (i == 0) chk("t1_latency", M'(lat), M'(2));
      take();
      chk($sformatf("dir%0d_release", i), M'(out_valid), M'(0));
    end

    // zero divisor: one-cycle path
    send(M'(5), M'(0), lat);
    chk("zero_err", M'(out_err), M'(1));
    chk("zero_w", out_w, M'(0));
    chk("zero_latency", M'(lat), M'(1));
    take();

    // hold result with out_ready low; a competing in_valid must be ignored
    send(M'(1), M'(2), lat);
    hw = out_w; he = out_err; changes = 0;
    @(negedge clk);
    in_w = M'(7); in_z = M'(0); in_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_w !== hw || out_err !== he || in_ready !== 1'b0 || out_valid !== 1'b1) changes++;
    end
    chk("hold_changes", M'(changes), M'(0));
    chk("hold_w", out_w, XINV);
    // release and upstream valid together: output leaves, input waits for IDLE
    @(negedge clk);
    in_w = M'(4); in_z = M'(2); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_out_valid", M'(out_valid), M'(0));
    chk("rel_in_ready", M'(in_ready), M'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("queued_busy", M'(busy), M'(1));
    lat = 1;
    while (!out_valid && lat < 4*M + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("queued_w", out_w, M'(2));
    chk("queued_err", M'(out_err), M'(0));
    take();

    // reset in the middle of CALC
    @(negedge clk);
    in_w = M'(1); in_z = XINV; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", M'(busy), M'(1));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", M'(busy), M'(0));
    chk("abort_valid", M'(out_valid), M'(0));
    chk("abort_in_ready", M'(in_ready), M'(1));
    @(negedge clk) rst = 1'b0;
    send(M'(3), M'(3), lat);
    chk("after_rst_w", out_w, M'(1));
    take();

    // random nonzero pairs, checked by multiplying back
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 6; k++) begin
        rw = {rw[M-33:0], 32'($urandom)};
        rz = {rz[M-33:0], 32'($urandom)};
      end
      if (rz == '0) rz = M'(1);
      send(rw, rz, lat);
      chk($sformatf("rnd%0d_mul", n), gf_mul(out_w, rz), rw);
      chk($sformatf("rnd%0d_err", n), M'(out_err), M'(0));
      chk($sformatf("rnd%0d_bound", n), M'(lat - 2 <= 4*M), M'(1));
      take();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
